// File: rtl/mod10_run_ctrl.sv
// rtl/mod10_run_ctrl.sv - debounced run/pause/clear controller with dual-rate mod-10 digit
module mod10_run_ctrl #(
  parameter int SLOW_DIV   = 25000000,
  parameter int FAST_DIV   = 12500000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Btn_Run,
  input  logic       Btn_Mode,
  input  logic       Btn_Clr,
  output logic [3:0] Digit,
  output logic       Carry,
  output logic       Tick,
  output logic       Mode_O,
  output logic [1:0] State,
  output logic       Running
);

  localparam int            DW        = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES);
  localparam logic [31:0]   SLOW_LAST = 32'(SLOW_DIV - 1);
  localparam logic [31:0]   FAST_LAST = 32'(FAST_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  // Button lanes: bit 0 = run, bit 1 = mode, bit 2 = clear.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [2:0]    deb_d;
  logic [DW-1:0] deb_cnt [3];
  logic [2:0]    press;
  logic          run_ev;
  logic          mode_ev;
  logic          clr_ev;

  state_t        state;
  state_t        state_nx;
  logic [31:0]   div_cnt;
  logic [31:0]   div_cnt_nx;
  logic [31:0]   div_last;
  logic [3:0]    digit_nx;
  logic          mode_nx;
  logic          tick_nx;
  logic          carry_nx;

  assign btn_raw = {Btn_Clr, Btn_Mode, Btn_Run};
  assign press   = deb & ~deb_d;
  assign run_ev  = press[0];
  assign mode_ev = press[1];
  assign clr_ev  = press[2];
  assign State   = state;

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a level change is accepted only after it has been stable for DEB_CYCLES clocks;
  // deb_d keeps the previous debounced level for rising-edge press detection.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // Next-state, divider and digit logic; clear beats run, mode rides along with either and
  // always restarts the divider, which also swallows a tick that would land in that cycle.
  always_comb begin
    state_nx   = state;
    div_cnt_nx = div_cnt;
    digit_nx   = Digit;
    mode_nx    = Mode_O;
    tick_nx    = 1'b0;
    carry_nx   = 1'b0;
    div_last   = Mode_O ? FAST_LAST : SLOW_LAST;

    if (mode_ev) begin
      mode_nx = ~Mode_O;
    end

    if (clr_ev) begin
      state_nx   = IDLE;
      digit_nx   = 4'd0;
      div_cnt_nx = '0;
    end else if (run_ev) begin
      // Leaving RUN holds DIV_CNT so a later resume continues mid-period.
      case (state)
        IDLE:    state_nx = RUN;
        RUN:     state_nx = PAUSE;
        default: state_nx = RUN;
      endcase
    end else if (!mode_ev && (state == RUN)) begin
      if (div_cnt == div_last) begin
        div_cnt_nx = '0;
        tick_nx    = 1'b1;
        if (Digit == 4'd9) begin
          digit_nx = 4'd0;
          carry_nx = 1'b1;
        end else begin
          digit_nx = Digit + 4'd1;
        end
      end else begin
        div_cnt_nx = div_cnt + 32'd1;
      end
    end else if (state == IDLE) begin
      div_cnt_nx = '0;
    end

    if (mode_ev) begin
      div_cnt_nx = '0;
    end
  end

  // State, divider and all visible outputs are registered together.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      Digit   <= 4'd0;
      Mode_O  <= 1'b0;
      Tick    <= 1'b0;
      Carry   <= 1'b0;
      Running <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_cnt_nx;
      Digit   <= digit_nx;
      Mode_O  <= mode_nx;
      Tick    <= tick_nx;
      Carry   <= carry_nx;
      Running <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_mod10_run_ctrl.sv
// tb/tb_mod10_run_ctrl.sv - self-checking bench for mod10_run_ctrl
module tb_mod10_run_ctrl;

  localparam int SLOW = 10;
  localparam int FAST = 5;
  localparam int DEB  = 4;
  // Cycles from the bench driving a button (just after an edge) to the edge where the output changes.
  localparam int LAT  = DEB + 4;

  logic       Clk;
  logic       Rst_n;
  logic       Btn_Run;
  logic       Btn_Mode;
  logic       Btn_Clr;
  logic [3:0] Digit;
  logic       Carry;
  logic       Tick;
  logic       Mode_O;
  logic [1:0] State;
  logic       Running;

  mod10_run_ctrl #(
    .SLOW_DIV  (SLOW),
    .FAST_DIV  (FAST),
    .DEB_CYCLES(DEB)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Btn_Run (Btn_Run),
    .Btn_Mode(Btn_Mode),
    .Btn_Clr (Btn_Clr),
    .Digit   (Digit),
    .Carry   (Carry),
    .Tick    (Tick),
    .Mode_O  (Mode_O),
    .State   (State),
    .Running (Running)
  );

  typedef struct {
    int         cyc;
    logic [3:0] digit;
    logic       carry;
  } tick_t;

  typedef struct {
    int         btn;
    logic [7:0] pat;
    int         plen;
    int         hold;
    int         st;
    int         md;
  } vec_t;

  tick_t sb[$];
  vec_t  vt[6];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_tick(input int c, input int d, input logic cy);
    tick_t t;
    t.cyc   = c;
    t.digit = 4'(d);
    t.carry = cy;
    sb.push_back(t);
  endtask

  task automatic next_edge();
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) next_edge();
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       Btn_Run  = v;
      1:       Btn_Mode = v;
      default: Btn_Clr  = v;
    endcase
  endtask

  // Tick scoreboard: every Tick must match the oldest expected tick in cycle, digit and carry.
  always begin
    tick_t e;
    @(posedge Clk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL tick_missing: actual no Tick, expected Tick with digit %0d at cycle %0d", e.digit, e.cyc);
    end
    if (Tick) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tick_unexpected: actual Tick with digit %0d, expected no Tick (cycle %0d)", Digit, cyc);
      end else begin
        e = sb.pop_front();
        check("tick_cycle", cyc, e.cyc);
        check("tick_digit", Digit, e.digit);
        check("tick_carry", Carry, e.carry);
      end
    end else if (Carry) begin
      n_checks++;
      n_fail++;
      $display("FAIL carry_without_tick: actual Carry=1, expected 0 (cycle %0d)", cyc);
    end
  end

  initial begin
    int k, ev, p, q, t2, q2, m, t4, p3, c, k6, r6;

    vt[0] = '{0, 8'h07, 3, 0, 0, 0};  // 3-wide run glitch: ignored
    vt[1] = '{1, 8'h07, 3, 0, 0, 0};  // 3-wide mode glitch: ignored
    vt[2] = '{1, 8'h0D, 5, 8, 0, 1};  // bounce 1,0,1,1,0 then steady: one toggle
    vt[3] = '{1, 8'h01, 1, 0, 0, 1};  // single-cycle blip: ignored
    vt[4] = '{1, 8'h00, 0, 6, 0, 0};  // clean press: toggles back
    vt[5] = '{2, 8'h00, 0, 6, 0, 0};  // clear in IDLE: no change, mode kept

    Rst_n    = 1'b0;
    Btn_Run  = 1'b0;
    Btn_Mode = 1'b0;
    Btn_Clr  = 1'b0;
    repeat (2) next_edge();
    check("rst_digit", Digit, 0);
    check("rst_carry", Carry, 0);
    check("rst_tick", Tick, 0);
    check("rst_mode", Mode_O, 0);
    check("rst_state", State, 0);
    check("rst_running", Running, 0);
    Rst_n = 1'b1;
    repeat (3) next_edge();

    // Debounce vectors applied in IDLE.
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vt[i].plen; j++) begin
        set_btn(vt[i].btn, vt[i].pat[j]);
        next_edge();
      end
      for (int j = 0; j < vt[i].hold; j++) begin
        set_btn(vt[i].btn, 1'b1);
        next_edge();
      end
      set_btn(vt[i].btn, 1'b0);
      repeat (20) next_edge();
      check($sformatf("vec%0d_state", i), State, vt[i].st);
      check($sformatf("vec%0d_mode", i), Mode_O, vt[i].md);
      check($sformatf("vec%0d_running", i), Running, 0);
      check($sformatf("vec%0d_digit", i), Digit, 0);
    end

    // Run press held 20 clocks: exact latency, then slow ticks through a 9->0 wrap up to Digit=7.
    k = cyc;
    Btn_Run = 1'b1;
    ev = k + LAT;
    wait_until(ev - 1);
    check("t1_state_before", State, 0);
    wait_until(ev);
    check("t1_state_run", State, 1);
    check("t1_running", Running, 1);
    check("t1_digit0", Digit, 0);
    for (int i = 1; i <= 17; i++) push_tick(ev + SLOW * i, i % 10, i == 10);
    wait_until(k + 20);
    Btn_Run = 1'b0;

    // Pause at Digit=7 with DIV_CNT=3, hold 50+ clocks, resume needs 7 more clocks.
    p = ev + 170 + 4;
    wait_until(p - LAT);
    Btn_Run = 1'b1;
    wait_until(p - 1);
    check("t4_state_pre", State, 1);
    wait_until(p);
    check("t4_state_pause", State, 2);
    check("t4_running", Running, 0);
    check("t4_digit", Digit, 7);
    wait_until(p + 2);
    Btn_Run = 1'b0;
    q = p + 52;
    wait_until(q - LAT);
    Btn_Run = 1'b1;
    wait_until(q - 1);
    check("t4_digit_frozen", Digit, 7);
    check("t4_state_held", State, 2);
    wait_until(q);
    check("t4_resume", State, 1);
    push_tick(q + 7, 8, 1'b0);
    push_tick(q + 17, 9, 1'b0);
    push_tick(q + 27, 0, 1'b1);
    wait_until(q + 2);
    Btn_Run = 1'b0;

    // Pause exactly on the terminal-count cycle: tick suppressed, resume fires after one clock.
    t2 = q + 27;
    wait_until(t2 + 10 - LAT);
    Btn_Run = 1'b1;
    wait_until(t2 + 10);
    check("term_state", State, 2);
    check("term_tick", Tick, 0);
    check("term_digit", Digit, 0);
    wait_until(t2 + 12);
    Btn_Run = 1'b0;
    q2 = t2 + 40;
    wait_until(q2 - LAT);
    Btn_Run = 1'b1;
    wait_until(q2 - 1);
    check("term_digit_held", Digit, 0);
    wait_until(q2);
    check("term_resume", State, 1);
    push_tick(q2 + 1, 1, 1'b0);

    // Mode at DIV_CNT=6: divider restarts, fast period of 5 from then on.
    Btn_Mode = 1'b1;
    m = q2 + 1 + 7;
    wait_until(q2 + 2);
    Btn_Run = 1'b0;
    wait_until(m - 1);
    check("t3_mode_before", Mode_O, 0);
    wait_until(m);
    check("t3_mode_after", Mode_O, 1);
    check("t3_tick_none", Tick, 0);
    check("t3_state", State, 1);
    push_tick(m + 5, 2, 1'b0);
    push_tick(m + 10, 3, 1'b0);
    push_tick(m + 15, 4, 1'b0);
    wait_until(m + 2);
    Btn_Mode = 1'b0;

    // Clear and run together while paused: clear wins.
    t4 = m + 15;
    p3 = t4 + 2;
    wait_until(p3 - LAT);
    Btn_Run = 1'b1;
    wait_until(p3);
    check("t5_paused", State, 2);
    check("t5_paused_digit", Digit, 4);
    wait_until(t4 + 4);
    Btn_Run = 1'b0;
    c = p3 + 30;
    wait_until(c - LAT);
    Btn_Run = 1'b1;
    Btn_Clr = 1'b1;
    wait_until(c - 1);
    check("t5_running_pre", Running, 0);
    wait_until(c);
    check("t5_state_idle", State, 0);
    check("t5_digit_zero", Digit, 0);
    check("t5_running", Running, 0);
    check("t5_mode_kept", Mode_O, 1);
    wait_until(c + 1);
    check("t5_running_stays", Running, 0);
    wait_until(c + 2);
    Btn_Run = 1'b0;
    Btn_Clr = 1'b0;

    // Run in fast mode up to Digit=5, then asynchronous reset between edges.
    k6 = c + 20;
    wait_until(k6);
    Btn_Run = 1'b1;
    r6 = k6 + LAT;
    for (int i = 1; i <= 5; i++) push_tick(r6 + FAST * i, i, 1'b0);
    wait_until(k6 + 10);
    Btn_Run = 1'b0;
    wait_until(r6 + 25);
    check("t6_digit5", Digit, 5);
    #2;
    Rst_n = 1'b0;
    #1;
    check("t6_async_digit", Digit, 0);
    check("t6_async_state", State, 0);
    check("t6_async_running", Running, 0);
    check("t6_async_mode", Mode_O, 0);
    check("t6_async_tick", Tick, 0);
    check("t6_async_carry", Carry, 0);
    repeat (3) next_edge();
    Rst_n = 1'b1;
    repeat (40) next_edge();
    check("t6_idle_state", State, 0);
    check("t6_idle_digit", Digit, 0);

    // Run bounce 1,0,1,1,0 then steady: exactly one event, latency from the steady run.
    k = cyc;
    for (int j = 0; j < 5; j++) begin
      Btn_Run = ((8'h0D >> j) & 8'h01) != 0;
      next_edge();
    end
    Btn_Run = 1'b1;
    wait_until(k + 12);
    check("t2_state_before", State, 0);
    wait_until(k + 13);
    check("t2_state_run", State, 1);
    push_tick(k + 23, 1, 1'b0);
    wait_until(k + 20);
    Btn_Run = 1'b0;
    wait_until(k + 24);
    check("t2_state_still_run", State, 1);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mod10_run_ctrl.md
# mod10_run_ctrl

Run/pause/rate controller for the decimal up-counter display path. Debounces three push-buttons, sequences a run/pause/clear state machine, generates a one-cycle count tick from the board clock at one of two selectable rates, and maintains the mod-10 digit with a carry pulse. It replaces the free-running divider-plus-counter arrangement: the divider restarts cleanly on every rate change, and counting is gated by the state machine.

## Interface
Parameters:
- SLOW_DIV, 25000000, clocks per tick when Mode_O=0; legal minimum is 2
- FAST_DIV, 12500000, clocks per tick when Mode_O=1; legal minimum is 2
- DEB_CYCLES, 1000000, consecutive stable clocks required before a debounced button level changes; legal minimum is 1

Ports:
- Clk  in  1  system clock; all logic on posedge
- Rst_n  in  1  asynchronous, active-low reset
- Btn_Run  in  1  raw button, active-high, asynchronous to Clk
- Btn_Mode  in  1  raw button, active-high, asynchronous to Clk
- Btn_Clr  in  1  raw button, active-high, asynchronous to Clk
- Digit  out  4  current count, 0..9
- Carry  out  1  one-cycle pulse on the 9->0 wrap
- Tick  out  1  one-cycle pulse when Digit advances
- Mode_O  out  1  active rate: 0 = SLOW_DIV, 1 = FAST_DIV
- State  out  2  00 IDLE, 01 RUN, 10 PAUSE; 11 is never produced
- Running  out  1  high when State == RUN

## Operation
- Each button passes through:
  - a 2-FF synchronizer, then
  - a debouncer: a counter increments while the synchronized level differs from the debounced level, and clears otherwise. When the count reaches DEB_CYCLES, the debounced level takes the synchronized level and the counter clears.
- A press event is a 0->1 transition of the debounced level. Release generates no event.
- Events per cycle, in priority order:
  1. Clr: any state -> IDLE; Digit = 0; divider = 0.
  2. Run: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  3. Mode: toggles Mode_O in any state and clears the divider to 0.
- Combining events in the same cycle:
  - Clr and Run together: Clr wins and Run is discarded.
  - Mode is applied alongside Clr or Run.
- Divider: 32-bit count DIV_CNT, with DIV = Mode_O ? FAST_DIV : SLOW_DIV.
  - RUN: when DIV_CNT == DIV-1, Tick pulses, DIV_CNT returns to 0, and Digit increments. Otherwise DIV_CNT increments.
  - PAUSE: DIV_CNT and Digit hold. Resuming continues from the held DIV_CNT.
  - IDLE: DIV_CNT is held at 0.
- Digit: on a Tick, 9 -> 0 with Carry = 1 in the same cycle as Tick; otherwise Digit increments by 1.
- A Mode toggle clears DIV_CNT. A tick that would have fired in that cycle is suppressed, so the next tick arrives exactly DIV(new) cycles later.
- A Run event out of RUN (into PAUSE) in a terminal-count cycle also suppresses the tick.

## Timing
- Reset values: Digit = 0, Carry = 0, Tick = 0, Mode_O = 0, State = IDLE, Running = 0. Synchronizers, debounced levels, debounce counters and DIV_CNT are all 0.
- Reset asserted mid-operation clears everything immediately, independent of Clk. The first event possible after release is a fresh debounced press.
- Press latency: from the first posedge sampling Btn_* high to the output change is exactly DEB_CYCLES+3 clocks (2 synchronizer + DEB_CYCLES debounce + 1 register), provided the input stays stable.
- A glitch shorter than DEB_CYCLES clocks after synchronization produces no event.
- Tick, Carry, Digit, State, Running and Mode_O are all registered. Tick and Carry are high for exactly one cycle.
- In RUN with no events, the Tick period is exactly DIV clocks. The first Tick after IDLE->RUN arrives DIV clocks after State becomes RUN.
- Running, State and Digit update on the same edge.

## Test plan
Common parameters: SLOW_DIV=10, FAST_DIV=5, DEB_CYCLES=4.
1. Reset, then a Btn_Run press held 20 clocks -> State=01 exactly 7 clocks after the first sampled-high edge. Ticks then arrive every 10 clocks, and Digit steps 0..9 then 0, with Carry high only in the 9->0 cycle.
2. Btn_Run pulse 3 clocks wide -> no State change. Bounce pattern 1,0,1,1,0 then steady high -> exactly one event.
3. In RUN at DIV_CNT=6, press Mode -> Mode_O=1 and DIV_CNT=0, with no tick in that cycle. The next Tick comes 5 clocks later, and the period is 5 thereafter.
4. In RUN with Digit=7, press Run -> PAUSE with Digit and DIV_CNT frozen for 50 clocks. Press Run again -> the first Tick lands after the remaining (10 - held DIV_CNT) clocks.
5. Clr and Run debounced in the same cycle while in PAUSE -> State=IDLE and Digit=0, with Running staying 0.
6. Pull Rst_n low mid-RUN at Digit=5, between clock edges -> all outputs reach their reset values before the next posedge. After release, with no button activity, there are no Ticks.
